// File: rtl/tms320c1x_pkg.sv
// Shared definitions for the TMS320C1x instruction sequencer.
//   SeqState_t  : sequencer FSM states
//   NOP_OP      : opcode held in IC after reset / illegal-instruction retire
//   ISR_OP      : pseudo-opcode placed in IC on interrupt entry
//   IsTwoWord() : opcode needs a second program word (branch/call target)
package tms320c1x_pkg;

  localparam logic [15:0] NOP_OP = 16'h7F80;
  localparam logic [15:0] ISR_OP = 16'hF000;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FETCH2, S_EXEC} SeqState_t;

  // Fx group: 4/5/6 and 8..F carry a target word.
  function automatic logic IsTwoWord(input logic [15:0] op);
    return (op[15:12] == 4'hF) &&
           (op[11] || (op[11:8] == 4'h4) || (op[11:8] == 4'h5) || (op[11:8] == 4'h6));
  endfunction

endpackage

// File: rtl/tms320c1x_int_edge.sv
// External interrupt front end: synchronises the asynchronous INT_N pin and
// latches a pending flag on each 1->0 transition. A held-low level does not
// re-arm. A new edge in the same cycle as clr wins, so it is not lost.
//   clk, rst, en : clock, sync active-high reset, clock enable
//   int_n        : raw asynchronous interrupt pin (active low)
//   clr          : consume the pending request
//   pending      : registered pending flag
module tms320c1x_int_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic int_n,
  input  logic clr,
  output logic pending
);

  logic [SYNC-1:0] sync_q, sync_d;
  logic            prev_q, prev_d;
  logic            pend_q, pend_d;
  logic            fall;

  always_comb begin
    sync_d = {sync_q[SYNC-2:0], int_n};
    prev_d = sync_q[SYNC-1];
    fall   = prev_q & ~sync_q[SYNC-1];
    pend_d = fall | (pend_q & ~clr);
  end

  // Pin idles high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      pend_q <= 1'b0;
    end else if (en) begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/tms320c1x_seq.sv
// TMS320C1x instruction sequencer: fetches program words into IC (and the
// second word into IW2), steps the decoder STATE index, and injects ISR_OP
// at instruction boundaries when an unmasked interrupt is pending.
//   CLK, RST, EN         : clock, sync active-high reset, clock enable
//   PM_RD/PM_RDY/PM_DI   : program-memory read handshake and data
//   PC_INC               : datapath PC increment pulse, one per accepted word
//   IC, IW2, STATE, EXEC : instruction, second word, state index, apply strobe
//   LST, ILI             : decoder last-state / illegal-instruction flags
//   INT_N, INTM, INT_ACK : interrupt pin, mask, entry pulse
//   ILL_STB              : illegal-instruction retire pulse
module tms320c1x_seq
  import tms320c1x_pkg::*;
#(
  parameter int INT_SYNC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        PM_RD,
  input  logic        PM_RDY,
  input  logic [15:0] PM_DI,
  output logic        PC_INC,
  output logic [15:0] IC,
  output logic [15:0] IW2,
  output logic [1:0]  STATE,
  output logic        EXEC,
  input  logic        LST,
  input  logic        ILI,
  input  logic        INT_N,
  input  logic        INTM,
  output logic        INT_ACK,
  output logic        ILL_STB
);

  SeqState_t   state_q, state_d;
  logic [15:0] ic_q, ic_d, iw2_q, iw2_d;
  logic [1:0]  step_q, step_d;
  logic        pm_rd_q, pm_rd_d, pc_inc_q, pc_inc_d, exec_q, exec_d;
  logic        int_ack_q, int_ack_d, ill_stb_q, ill_stb_d;
  logic        int_pend, int_clr, boundary, take_int;

  tms320c1x_int_edge #(.SYNC(INT_SYNC)) u_int_edge (
    .clk     (CLK),
    .rst     (RST),
    .en      (EN),
    .int_n   (INT_N),
    .clr     (int_clr),
    .pending (int_pend)
  );

  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    iw2_d     = iw2_q;
    step_d    = step_q;
    pc_inc_d  = 1'b0;
    int_ack_d = 1'b0;
    ill_stb_d = 1'b0;
    int_clr   = 1'b0;
    // Illegal retires like a last state. ISR_OP itself never nests.
    boundary  = (state_q == S_EXEC) && (LST || ILI);
    take_int  = boundary && int_pend && !INTM && (ic_q != ISR_OP);

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: if (PM_RDY) begin
        ic_d     = PM_DI;
        step_d   = 2'd0;
        pc_inc_d = 1'b1;
        state_d  = S_EXEC;
      end
      S_FETCH2: if (PM_RDY) begin
        iw2_d    = PM_DI;
        step_d   = 2'd1;
        pc_inc_d = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (boundary) begin
          if (ILI) begin
            ill_stb_d = 1'b1;
            ic_d      = NOP_OP;
          end
          if (take_int) begin
            ic_d      = ISR_OP;
            step_d    = 2'd0;
            int_ack_d = 1'b1;
            int_clr   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else if (step_q == 2'd0 && IsTwoWord(ic_q)) begin
          state_d = S_FETCH2;  // STATE stays 0 until the target word lands
        end else if (step_q != 2'd3) begin
          step_d = step_q + 2'd1;  // saturate at 3: decoder default arm
        end
      end
      default: state_d = S_IDLE;
    endcase

    pm_rd_d = (state_d == S_FETCH) || (state_d == S_FETCH2);
    exec_d  = (state_d == S_EXEC);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ic_q      <= NOP_OP;
      iw2_q     <= 16'h0000;
      step_q    <= 2'd0;
      pm_rd_q   <= 1'b0;
      pc_inc_q  <= 1'b0;
      exec_q    <= 1'b0;
      int_ack_q <= 1'b0;
      ill_stb_q <= 1'b0;
    end else if (EN) begin
      state_q   <= state_d;
      ic_q      <= ic_d;
      iw2_q     <= iw2_d;
      step_q    <= step_d;
      pm_rd_q   <= pm_rd_d;
      pc_inc_q  <= pc_inc_d;
      exec_q    <= exec_d;
      int_ack_q <= int_ack_d;
      ill_stb_q <= ill_stb_d;
    end
  end

  assign PM_RD   = pm_rd_q;
  assign PC_INC  = pc_inc_q;
  assign IC      = ic_q;
  assign IW2     = iw2_q;
  assign STATE   = step_q;
  assign EXEC    = exec_q;
  assign INT_ACK = int_ack_q;
  assign ILL_STB = ill_stb_q;

endmodule
